// File: rtl/camera_pkg.sv
// Shared definitions for the camera capture path: frame geometry defaults,
// coordinate width, capture FSM states and the RGB565 to RGB332 reduction.
package camera_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;
  localparam int COORD_W      = 11;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FRAME = 2'd1,
    ACTIVE     = 2'd2
  } cap_state_t;

  // Keep the top bits of each colour channel: R3 G3 B2
  function automatic logic [7:0] rgb565_to_332(input logic [7:0] hi, input logic [7:0] lo);
    return {hi[7:5], hi[2:0], lo[4:3]};
  endfunction

endpackage

// File: rtl/camera_capture_if.sv
// Framebuffer write port: one strobe plus the pixel value and its coordinates.
interface camera_capture_if;
  import camera_pkg::*;

  logic               write_enable;
  logic [7:0]         data_in;
  logic [COORD_W-1:0] data_in_x;
  logic [COORD_W-1:0] data_in_y;

  modport master (output write_enable, data_in, data_in_x, data_in_y);
  modport slave  (input  write_enable, data_in, data_in_x, data_in_y);

endinterface

// File: rtl/camera_capture_sync_edge.sv
// Multi-flop synchronizer for one asynchronous level, with single-cycle
// rise and fall pulses derived from the synchronized value.
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic CLOCK_50,
  input  logic reset_n,
  input  logic async_in,
  output logic sync_out,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_r;
  logic              prev_r;

  // Shift the input through the chain and remember the previous settled value
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      sync_r <= {STAGES{1'b0}};
      prev_r <= 1'b0;
    end else begin
      sync_r[0] <= async_in;
      for (int i = 1; i < STAGES; i++) begin
        sync_r[i] <= sync_r[i-1];
      end
      prev_r <= sync_r[STAGES-1];
    end
  end

  assign sync_out = sync_r[STAGES-1];
  assign rise     = sync_out & ~prev_r;
  assign fall     = ~sync_out & prev_r;

endmodule

// File: rtl/camera_capture.sv
// Captures an RGB565 camera stream (sampled on CLOCK_50) and writes RGB332
// pixels with their coordinates into a framebuffer, one frame at a time.
module camera_capture
  import camera_pkg::*;
#(
  parameter int H_ACTIVE    = H_ACTIVE_DEF,
  parameter int V_ACTIVE    = V_ACTIVE_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic              CLOCK_50,
  input  logic              reset_n,
  input  logic              cam_pclk,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic [7:0]        cam_data,
  input  logic              capture_en,
  camera_capture_if.master  fb,
  output logic              frame_done,
  output logic              capturing,
  output logic              overflow
);

  localparam logic [COORD_W-1:0] X_LIM = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] Y_LIM = COORD_W'(V_ACTIVE);

  logic pclk_sync_s, pclk_rise_s, pclk_fall_s;
  logic href_s, href_rise_s, href_fall_s;
  logic vsync_sync_s, vsync_rise_s, vsync_fall_s;
  logic [7:0] data_s;
  logic unused_s;

  logic [7:0]         data_sync_r [SYNC_STAGES];
  cap_state_t         state_r;
  logic [COORD_W-1:0] x_r;
  logic [COORD_W-1:0] y_r;
  logic               phase_r;
  logic [7:0]         hi_r;

  sync_edge #(.STAGES(SYNC_STAGES)) u_pclk_sync (
    .CLOCK_50(CLOCK_50), .reset_n(reset_n), .async_in(cam_pclk),
    .sync_out(pclk_sync_s), .rise(pclk_rise_s), .fall(pclk_fall_s)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_href_sync (
    .CLOCK_50(CLOCK_50), .reset_n(reset_n), .async_in(cam_href),
    .sync_out(href_s), .rise(href_rise_s), .fall(href_fall_s)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_vsync_sync (
    .CLOCK_50(CLOCK_50), .reset_n(reset_n), .async_in(cam_vsync),
    .sync_out(vsync_sync_s), .rise(vsync_rise_s), .fall(vsync_fall_s)
  );

  assign unused_s = ^{pclk_sync_s, pclk_fall_s, href_rise_s, vsync_sync_s};

  // Data bus uses the same depth as the strobes so each byte lines up with its pclk edge
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        data_sync_r[i] <= 8'h00;
      end
    end else begin
      data_sync_r[0] <= cam_data;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        data_sync_r[i] <= data_sync_r[i-1];
      end
    end
  end

  assign data_s = data_sync_r[SYNC_STAGES-1];

  // Capture FSM with pixel assembly, coordinate counters and registered outputs
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      state_r         <= IDLE;
      x_r             <= {COORD_W{1'b0}};
      y_r             <= {COORD_W{1'b0}};
      phase_r         <= 1'b0;
      hi_r            <= 8'h00;
      fb.write_enable <= 1'b0;
      fb.data_in      <= 8'h00;
      fb.data_in_x    <= {COORD_W{1'b0}};
      fb.data_in_y    <= {COORD_W{1'b0}};
      frame_done      <= 1'b0;
      capturing       <= 1'b0;
      overflow        <= 1'b0;
    end else begin
      fb.write_enable <= 1'b0;
      frame_done      <= 1'b0;
      case (state_r)
        IDLE: begin
          // Only a vsync rise arms capture, so a frame already in flight is skipped
          if (vsync_rise_s) begin
            state_r <= WAIT_FRAME;
          end
        end
        WAIT_FRAME: begin
          if (vsync_fall_s && capture_en) begin
            state_r   <= ACTIVE;
            capturing <= 1'b1;
            x_r       <= {COORD_W{1'b0}};
            y_r       <= {COORD_W{1'b0}};
            phase_r   <= 1'b0;
            overflow  <= 1'b0;
          end
        end
        ACTIVE: begin
          if (vsync_rise_s) begin
            state_r    <= WAIT_FRAME;
            capturing  <= 1'b0;
            frame_done <= 1'b1;
            phase_r    <= 1'b0;
          end else if (href_fall_s) begin
            // Line end wins over a coincident pclk edge and drops any dangling high byte
            x_r     <= {COORD_W{1'b0}};
            phase_r <= 1'b0;
            if (y_r < Y_LIM) begin
              y_r <= y_r + 11'd1;
            end
          end else if (pclk_rise_s && href_s) begin
            if (!phase_r) begin
              hi_r    <= data_s;
              phase_r <= 1'b1;
            end else begin
              phase_r <= 1'b0;
              if ((x_r < X_LIM) && (y_r < Y_LIM)) begin
                fb.write_enable <= 1'b1;
                fb.data_in      <= rgb565_to_332(hi_r, data_s);
                fb.data_in_x    <= x_r;
                fb.data_in_y    <= y_r;
              end else begin
                overflow <= 1'b1;
              end
              if (x_r < X_LIM) begin
                x_r <= x_r + 11'd1;
              end
            end
          end
        end
        default: begin
          state_r   <= IDLE;
          capturing <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_camera_capture.sv
// Directed bench for camera_capture on a reduced 8x4 frame; a pixel-level
// scoreboard built from the stream rules is compared against every write.
module tb_camera_capture;
  import camera_pkg::*;

  localparam int H  = 8;
  localparam int V  = 4;
  localparam int SS = 2;

  typedef struct packed {
    logic [7:0]  d;
    logic [10:0] x;
    logic [10:0] y;
  } wr_t;

  logic       CLOCK_50   = 1'b0;
  logic       reset_n    = 1'b0;
  logic       cam_pclk   = 1'b0;
  logic       cam_vsync  = 1'b0;
  logic       cam_href   = 1'b0;
  logic [7:0] cam_data   = 8'h00;
  logic       capture_en = 1'b1;
  logic       frame_done, capturing, overflow;

  camera_capture_if fb_if ();

  camera_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .SYNC_STAGES(SS)) dut (
    .CLOCK_50(CLOCK_50), .reset_n(reset_n), .cam_pclk(cam_pclk),
    .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_data(cam_data),
    .capture_en(capture_en), .fb(fb_if), .frame_done(frame_done),
    .capturing(capturing), .overflow(overflow)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int  errors = 0, checks = 0;
  wr_t exp_q[$];
  bit  armed = 1'b0, in_frame = 1'b0, ovf_exp = 1'b0;
  int  done_exp = 0, done_seen = 0, wr_seen = 0;
  logic [7:0]  log_d [512];
  logic [10:0] log_x [512];
  logic [10:0] log_y [512];
  logic [7:0]  last_d = 8'h00;
  logic [10:0] last_x = 11'd0, last_y = 11'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // RGB332 from RGB565 by channel arithmetic
  function automatic logic [7:0] model_pix(input int hi, input int lo);
    int r5, g6, b5;
    r5 = hi / 8;
    g6 = (hi % 8) * 8 + lo / 32;
    b5 = lo % 32;
    return 8'((r5 / 4) * 32 + (g6 / 8) * 4 + (b5 / 8));
  endfunction

  function automatic logic [7:0] hi_of(input int fid, input int line, input int px);
    if (fid == 1 && line == 0 && px == 0) return 8'hF8;
    if (fid == 1 && line == 0 && px == 1) return 8'h07;
    return 8'(fid * 37 + line * 11 + px * 5 + 1);
  endfunction

  function automatic logic [7:0] lo_of(input int fid, input int line, input int px);
    if (fid == 1 && line == 0 && px == 0) return 8'h1F;
    if (fid == 1 && line == 0 && px == 1) return 8'hE0;
    return 8'(fid * 13 + line * 7 + px * 29 + 3);
  endfunction

  task automatic model_pixel(input int line, input int px, input logic [7:0] hb, input logic [7:0] lb);
    wr_t e;
    if (in_frame) begin
      if (px < H && line < V) begin
        e.d = model_pix(int'(hb), int'(lb));
        e.x = 11'(px);
        e.y = 11'(line);
        exp_q.push_back(e);
      end else begin
        ovf_exp = 1'b1;
      end
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic vs_rise();
    cam_vsync = 1'b1;
    if (in_frame) done_exp++;
    in_frame = 1'b0;
    armed    = 1'b1;
    cyc(8);
  endtask

  task automatic vs_fall();
    cam_vsync = 1'b0;
    if (armed && capture_en) begin
      in_frame = 1'b1;
      ovf_exp  = 1'b0;
    end
    cyc(8);
  endtask

  task automatic send_byte(input logic [7:0] b);
    cam_data = b;
    cam_pclk = 1'b0;
    cyc(2);
    cam_pclk = 1'b1;
    cyc(2);
  endtask

  // mode 0: normal line end, 1: final pclk rise coincides with href fall, 2: leave href high
  task automatic send_line(input int fid, input int line, input int nbytes, input int mode);
    logic [7:0] hb, lb;
    cam_href = 1'b1;
    for (int b = 0; b < nbytes; b++) begin
      hb = hi_of(fid, line, b / 2);
      lb = lo_of(fid, line, b / 2);
      if (b % 2 == 0) begin
        send_byte(hb);
      end else begin
        send_byte(lb);
        model_pixel(line, b / 2, hb, lb);
      end
    end
    if (mode == 1) begin
      cam_data = lo_of(fid, line, nbytes / 2);
      cam_pclk = 1'b0;
      cyc(2);
      cam_pclk = 1'b1;
      cam_href = 1'b0;
      cyc(2);
    end
    if (mode != 2) begin
      cam_pclk = 1'b0;
      cam_href = 1'b0;
      cyc(8);
    end
  endtask

  task automatic lines(input int fid, input int first, input int count, input int nbytes);
    for (int l = first; l < first + count; l++) send_line(fid, l, nbytes, 0);
  endtask

  // Compare process: every write against the scoreboard, hold check otherwise
  initial begin
    wr_t e;
    forever begin
      @(negedge CLOCK_50);
      if (!reset_n) begin
        last_d = 8'h00;
        last_x = 11'd0;
        last_y = 11'd0;
      end else begin
        if (frame_done) done_seen++;
        if (fb_if.write_enable) begin
          if (wr_seen < 512) begin
            log_d[wr_seen] = fb_if.data_in;
            log_x[wr_seen] = fb_if.data_in_x;
            log_y[wr_seen] = fb_if.data_in_y;
          end
          wr_seen++;
          if (exp_q.size() == 0) begin
            check("unexpected_write", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("wr_data", fb_if.data_in, e.d);
            check("wr_x", fb_if.data_in_x, e.x);
            check("wr_y", fb_if.data_in_y, e.y);
          end
          last_d = fb_if.data_in;
          last_x = fb_if.data_in_x;
          last_y = fb_if.data_in_y;
        end else begin
          check("hold_data", fb_if.data_in, last_d);
          check("hold_x", fb_if.data_in_x, last_x);
          check("hold_y", fb_if.data_in_y, last_y);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    cyc(4);
    check("rst_we", fb_if.write_enable, 32'd0);
    check("rst_data", fb_if.data_in, 32'd0);
    check("rst_x", fb_if.data_in_x, 32'd0);
    check("rst_y", fb_if.data_in_y, 32'd0);
    check("rst_done", frame_done, 32'd0);
    check("rst_cap", capturing, 32'd0);
    check("rst_ovf", overflow, 32'd0);
    reset_n = 1'b1;
    cyc(4);

    // Stream joins mid-frame: nothing until a full vsync rise-then-fall
    lines(0, 0, 2, 16);
    check("midframe_writes", wr_seen, 32'd0);
    check("midframe_cap", capturing, 32'd0);

    // Frame 1: full frame, literal pixel pins
    vs_rise();
    vs_fall();
    check("f1_cap", capturing, 32'd1);
    base = wr_seen;
    lines(1, 0, 4, 16);
    vs_rise();
    check("f1_writes", wr_seen - base, 32'd32);
    check("f1_px0", log_d[base], 32'hE3);
    check("f1_px1", log_d[base + 1], 32'h1C);
    check("f1_last_x", log_x[wr_seen - 1], 32'd7);
    check("f1_last_y", log_y[wr_seen - 1], 32'd3);
    check("f1_done", done_seen, 32'd1);
    check("f1_ovf", overflow, 32'd0);

    // Frame 2: second full frame
    vs_fall();
    base = wr_seen;
    lines(2, 0, 4, 16);
    vs_rise();
    check("f2_writes", wr_seen - base, 32'd32);
    check("f2_done", done_seen, 32'd2);
    check("f2_ovf", overflow, 32'd0);

    // Frame 3: long line, odd line, pclk/href clash, extra line
    vs_fall();
    base = wr_seen;
    send_line(3, 0, 16, 0);
    send_line(3, 1, 20, 0);
    check("f3_ovf_set", overflow, 32'd1);
    send_line(3, 2, 17, 0);
    send_line(3, 3, 15, 1);
    send_line(3, 4, 16, 0);
    vs_rise();
    check("f3_writes", wr_seen - base, 32'd31);
    check("f3_ovf_sticky", overflow, 32'd1);
    check("f3_ovf_model", overflow, ovf_exp);

    // Frame 4: capture_en dropped mid-frame, frame still completes
    vs_fall();
    check("f4_ovf_clear", overflow, 32'd0);
    base = wr_seen;
    lines(4, 0, 2, 16);
    capture_en = 1'b0;
    lines(4, 2, 2, 16);
    vs_rise();
    check("f4_writes", wr_seen - base, 32'd32);
    check("f4_done", done_seen, 32'd4);

    // Frame 5: not captured
    vs_fall();
    base = wr_seen;
    lines(5, 0, 1, 16);
    check("f5_cap", capturing, 32'd0);
    lines(5, 1, 3, 16);
    vs_rise();
    check("f5_writes", wr_seen - base, 32'd0);
    check("f5_done", done_seen, 32'd4);
    capture_en = 1'b1;

    // Frame 6: one-cycle reset at row 2 abandons the frame
    vs_fall();
    base = wr_seen;
    lines(6, 0, 2, 16);
    reset_n = 1'b0;
    cyc(1);
    reset_n  = 1'b1;
    armed    = 1'b0;
    in_frame = 1'b0;
    ovf_exp  = 1'b0;
    lines(6, 2, 2, 16);
    check("f6_cap", capturing, 32'd0);
    vs_rise();
    check("f6_writes", wr_seen - base, 32'd16);
    check("f6_done", done_seen, 32'd4);

    // Frame 7: full frame after reset starts at (0,0)
    vs_fall();
    base = wr_seen;
    lines(7, 0, 4, 16);
    vs_rise();
    check("f7_writes", wr_seen - base, 32'd32);
    check("f7_first_x", log_x[base], 32'd0);
    check("f7_first_y", log_y[base], 32'd0);
    check("f7_done", done_seen, 32'd5);

    // Frame 8: vsync rises mid-line with a pending high byte
    vs_fall();
    base = wr_seen;
    send_line(8, 0, 16, 0);
    send_line(8, 1, 5, 2);
    vs_rise();
    cam_pclk = 1'b0;
    cam_href = 1'b0;
    cyc(8);
    check("f8_writes", wr_seen - base, 32'd10);
    check("f8_done", done_seen, 32'd6);
    check("f8_cap", capturing, 32'd0);

    check("done_model", done_seen, done_exp);
    check("exp_left", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
